lfsr_to_count: RTL and testbench
================================

# lfsr_to_count

Inverse of the team's counter-to-LFSR converter: takes an 8-bit LFSR state and finds the step count N that produces it from the fixed seed. It steps a reference LFSR from the seed until it matches the captured value, then latches N on `count_out` and raises `done`. It sits on the receive/check side of the LFSR datapath and recovers sequence positions from captured patterns.

## Interface
- `WIDTH`, 8: LFSR and count width.
- `SEED`, 8'h01: LFSR state defined as N = 0.
- `TAPS`, 8'hB8: feedback mask. Default is x^8+x^6+x^5+x^4+1, maximal length, period 255.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset. Synchronous, active-low.
- `start`  in  1: level input. A low-to-high transition requests a conversion.
- `value_in`  in  WIDTH: LFSR state to convert. Sampled only on the cycle the start edge is detected.
- `count_out`  out  WIDTH: recovered N. Valid while `done`=1.
- `done`  out  1: result (or error) valid. Held until the next accepted start.
- `busy`  out  1: search in progress.
- `err`  out  1: unreachable value. Meaningful only with `done`.

## Operation
- LFSR step: `fb = ^(lfsr & TAPS)`, `next = {lfsr[WIDTH-2:0], fb}`. With the defaults, 01→02→04…; 80→01.
- Edge detect: `start_q` is a register. An edge is `start & ~start_q`.
- `start_q` resets to 0, so `start` held high through reset release counts as an edge.
- FSM states:
  - IDLE: waiting for a start edge.
  - SEARCH: stepping the reference LFSR.
  - DONE: result held on the outputs.
- IDLE or DONE with a start edge:
  - Capture `target <= value_in`, `lfsr <= SEED`, `cnt <= 0`.
  - Clear `done`, `err` and `count_out`. Go to SEARCH.
- IDLE or DONE with no start edge: hold.
- SEARCH, each cycle:
  - If `lfsr == target`: `count_out <= cnt`, `done <= 1`, `err <= 0`, go to DONE.
  - Else if `cnt == 2^WIDTH-2`: `err <= 1`, `done <= 1`, `count_out <= 0`, go to DONE. This covers the lock-up value 0 and non-maximal TAPS.
  - Else: `lfsr <= next`, `cnt <= cnt+1`.
- Start edges during SEARCH are ignored. `value_in` changes during SEARCH have no effect.
- `busy` = (state == SEARCH), registered.
- Reset (any state, including mid-search) sets:
  - state IDLE;
  - `count_out`=0, `done`=0, `busy`=0, `err`=0;
  - `lfsr`=SEED, `cnt`=0, `target`=0, `start_q`=0.
- No partial result is exposed.

## Timing
- Call the cycle where the edge is sampled cycle 0. SEARCH begins in cycle 1.
- Valid value: `done`/`count_out` visible in cycle N+2. Latency is N+2 cycles, N ∈ 0..2^WIDTH-2 (max 256 with the defaults).
- Invalid value: `done`=1 with `err`=1 in cycle 2^WIDTH (256 with the defaults).
- `busy` is high from cycle 1 through the cycle before `done` rises. It is never high together with `done`.
- A new start edge in DONE clears `done` on the next clock edge. Back-to-back conversions are therefore separated by at least one `done` cycle.

## Structure
- Shared package `lfsr_pkg`, shared with the forward converter:
  - state enum `{IDLE, SEARCH, DONE}`;
  - default `SEED`/`TAPS` constants;
  - function `lfsr_next(state, taps)`.
- One sub-module, `lfsr_core`: WIDTH-bit register with synchronous load-seed and step-enable, output = state. The FSM, counter and compare stay in the top level.

## Test plan
- Reset, then `value_in`=8'h01 with a start pulse → `count_out`=0, `done`=1 in cycle 2, `err`=0, `busy` high for exactly cycle 1.
- `value_in`=8'h02 → `count_out`=1 at cycle 3. `value_in`=8'h80 → `count_out`=254 at cycle 256.
- `value_in`=8'h00 → `done`=1, `err`=1, `count_out`=0 at cycle 256.
- Start 8'h80, then a second start edge at cycle 10 with 8'h02 → second edge ignored; result 254.
- Assert `reset_n`=0 at cycle 50 of a search → next cycle all outputs 0, state IDLE. A new start with 8'h04 then yields `count_out`=2.
- Sweep all 255 nonzero values, cross-checked against the forward converter model → each round-trips N exactly; `start` held high across reset release triggers one conversion.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the counter<->LFSR converter pair: FSM states,
// default polynomial/seed and the single-step function.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W    = 32;
    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam logic [7:0]  DEFAULT_SEED  = 8'h01;
    localparam logic [7:0]  DEFAULT_TAPS  = 8'hB8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } lfsr_state_e;

    // One Fibonacci step; state/taps are zero-extended, result masked to width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] mask;
        fb   = ^(state & taps);
        mask = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
        return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Reference LFSR register: synchronous seed load and step enable.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_seed_i) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS), WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_to_count.sv
// LFSR state -> step count: walks a reference LFSR from SEED until it matches
// the captured value, then holds the step count (or an unreachable flag).
module lfsr_to_count
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0] count_out,
    output logic             done,
    output logic             busy,
    output logic             err
);

    // Last count reachable by a maximal-length sequence (2^WIDTH-2).
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             start_q;
    logic             start_edge_c;
    logic             load_seed_c;
    logic             step_c;
    logic [WIDTH-1:0] lfsr_c;

    assign start_edge_c = start & ~start_q;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_seed_i (load_seed_c),
        .step_i      (step_c),
        .state_o     (lfsr_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        count_d     = count_q;
        done_d      = done_q;
        err_d       = err_q;
        load_seed_c = 1'b0;
        step_c      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge_c) begin
                    target_d    = value_in;
                    load_seed_c = 1'b1;
                    cnt_d       = '0;
                    count_d     = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    state_d     = SEARCH;
                end
            end
            SEARCH: begin
                if (lfsr_c == target_q) begin
                    count_d = cnt_q;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Whole sequence walked: lock-up state or short-cycle taps.
                    count_d = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    step_c = 1'b1;
                    cnt_d  = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SEARCH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            count_q  <= count_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            start_q  <= start;
        end
    end

    assign count_out = count_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lfsr_to_count.sv
// Directed bench for lfsr_to_count: latency, error path, ignored edges,
// mid-search reset, held-start reset release and a full round-trip sweep.
module tb_lfsr_to_count;
    import lfsr_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] value_in;
    logic [7:0] count_out;
    logic       done;
    logic       busy;
    logic       err;

    int n_checks;
    int n_errors;
    int pos [256];

    lfsr_to_count dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .value_in  (value_in),
        .count_out (count_out),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    // Called just before the posedge that samples the start edge (cycle 0).
    // inject: drop start at cycle 5, new edge with 8'h02 at cycle 10.
    task automatic wait_result(input int exp_n, input bit exp_err, input string tag, input bit inject);
        int cyc;
        bit busy_ok;
        busy_ok = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inject && cyc == 5) start = 1'b0;
            if (inject && cyc == 10) begin
                start    = 1'b1;
                value_in = 8'h02;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_done"},  32'(done),      32'd1);
        chk({tag, "_cycle"}, 32'(cyc),       exp_err ? 32'd256 : 32'(exp_n + 2));
        chk({tag, "_count"}, 32'(count_out), exp_err ? 32'd0 : 32'(exp_n));
        chk({tag, "_err"},   32'(err),       32'(exp_err));
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic conv(input logic [7:0] v, input int exp_n, input bit exp_err, input string tag);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        value_in = v;
        start    = 1'b1;
        wait_result(exp_n, exp_err, tag, 1'b0);
    endtask

    initial begin
        logic [7:0] s;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        value_in = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Hand-computed positions: 01 is the seed, 80 is its predecessor.
        conv(8'h01, 0, 1'b0, "v01");
        @(negedge clk);
        chk("v01_hold_done", 32'(done), 32'd1);
        conv(8'h02, 1, 1'b0, "v02");
        conv(8'h04, 2, 1'b0, "v04");
        conv(8'h80, 254, 1'b0, "v80");
        conv(8'h00, 0, 1'b1, "v00");

        // Second edge mid-search is ignored
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        value_in = 8'h80;
        start    = 1'b1;
        wait_result(254, 1'b0, "ignore", 1'b1);

        // Reset at cycle 50 of a search
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        value_in = 8'h80;
        start    = 1'b1;
        @(posedge clk);
        repeat (49) @(posedge clk);
        #1;
        chk("midrst_busy_c50", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_count", 32'(count_out), 32'd0);
        chk("midrst_done",  32'(done), 32'd0);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_err",   32'(err),  32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        conv(8'h04, 2, 1'b0, "after_rst");

        // Start held high through reset release: exactly one conversion
        @(negedge clk);
        reset_n  = 1'b0;
        start    = 1'b1;
        value_in = 8'h02;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_result(1, 1'b0, "held", 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("held_done_stays", 32'(done), 32'd1);
        chk("held_no_rerun",   32'(busy), 32'd0);

        // Forward-converter model: position of every state reached from the seed
        for (int i = 0; i < 256; i++) pos[i] = -1;
        s = 8'h01;
        for (int n = 0; n < 255; n++) begin
            if (pos[s] < 0) pos[s] = n;
            s = ref_step(s);
        end
        for (int v = 1; v < 256; v++) begin
            if (pos[v] >= 0) conv(8'(v), pos[v], 1'b0, $sformatf("sweep_%02h", v));
            else             conv(8'(v), 0, 1'b1, $sformatf("sweep_%02h", v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
